// File: rtl/spi_pkg.sv
// Shared types and helpers for the generic SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    TRAIL,
    HOLD,
    DONE
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // Word bit position carrying serial bit number n of a width-bit word.
  function automatic int unsigned bit_sel(input logic lsb_first,
                                          input int unsigned n,
                                          input int unsigned width);
    return lsb_first ? n : (width - 1 - n);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, SCLK level and edge strobes.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic toggle_en,
  input  logic track,
  input  logic cpol_in,
  input  logic cpol_lat,
  output logic sclk,
  output logic tick,
  output logic toggle,
  output logic lead,
  output logic trail
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Terminal-count strobe; leading edge leaves the idle level, trailing returns to it.
  always_comb begin
    tick   = en && (cnt == LAST);
    toggle = tick && toggle_en;
    lead   = toggle && (sclk == cpol_lat);
    trail  = toggle && (sclk != cpol_lat);
  end

  // Half-period counter, wraps at CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  // SCLK follows the idle level when tracking, otherwise toggles at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk <= 1'b0;
    end else if (track) begin
      sclk <= cpol_in;
    end else if (toggle) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master with level enable / finish handshake.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CS_HOLD = 4,
  parameter int unsigned NUM_CS  = 1
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          SPI_EN,
  input  logic [DATA_W-1:0]                             TX_DATA,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] CS_SEL,
  input  logic                                          CPOL,
  input  logic                                          CPHA,
  input  logic                                          LSB_FIRST,
  input  logic                                          MISO,
  output logic [NUM_CS-1:0]                             CS_N,
  output logic                                          SCLK,
  output logic                                          MOSI,
  output logic [DATA_W-1:0]                             RX_DATA,
  output logic                                          BUSY,
  output logic                                          SPI_FIN
);

  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned TW = $clog2(2 * DATA_W + 1);
  localparam int unsigned HW = $clog2(CS_HOLD + 1);

  if (DATA_W < 1 || DATA_W > 32) begin : g_chk_data_w
    $error("spi_master_gen: DATA_W must be in 1..32");
  end
  if (CLK_DIV < 2) begin : g_chk_clk_div
    $error("spi_master_gen: CLK_DIV must be >= 2");
  end
  if (CS_HOLD < 1) begin : g_chk_cs_hold
    $error("spi_master_gen: CS_HOLD must be >= 1");
  end
  if (NUM_CS < 1 || NUM_CS > 8) begin : g_chk_num_cs
    $error("spi_master_gen: NUM_CS must be in 1..8");
  end

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_lat;
  logic [DATA_W-1:0] rx_sh;
  logic [TW-1:0]     tcnt;
  logic [HW-1:0]     hcnt;

  logic              run;
  logic              shifting;
  logic              track;
  logic              tick;
  logic              toggle;
  logic              lead;
  logic              trail;
  logic              sclk_int;

  int unsigned       cur_bit;
  logic [IW-1:0]     cur_idx;
  logic [IW-1:0]     nxt_idx;
  logic [IW-1:0]     first_idx;
  logic              last_bit;
  logic [NUM_CS-1:0] sel_mask;

  // Clock-generator controls; SCLK re-tracks CPOL on any edge that lands in IDLE.
  always_comb begin
    run      = (state == SETUP) || (state == XFER) || (state == TRAIL);
    shifting = (state == SETUP) || (state == XFER);
    track    = (state == IDLE) || ((state == DONE) && !SPI_EN);
  end

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (CLK),
    .rst      (RST),
    .en       (run),
    .clr      (state == IDLE),
    .toggle_en(shifting),
    .track    (track),
    .cpol_in  (CPOL),
    .cpol_lat (mode.cpol),
    .sclk     (sclk_int),
    .tick     (tick),
    .toggle   (toggle),
    .lead     (lead),
    .trail    (trail)
  );

  assign SCLK = sclk_int;

  // Bit indices: each SCLK period (pair of toggles) carries one serial bit.
  // Out-of-range selects shift the one-hot past the top, so no CS asserts.
  always_comb begin
    cur_bit   = 32'(tcnt >> 1);
    cur_idx   = IW'(bit_sel(mode.lsb_first, cur_bit, DATA_W));
    nxt_idx   = IW'(bit_sel(mode.lsb_first, cur_bit + 1, DATA_W));
    first_idx = IW'(bit_sel(LSB_FIRST, 0, DATA_W));
    last_bit  = (cur_bit == DATA_W - 1);
    sel_mask  = NUM_CS'(1) << CS_SEL;
  end

  // Transfer FSM with registered CS_N, MOSI, RX_DATA, BUSY and SPI_FIN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      mode    <= '0;
      tx_lat  <= '0;
      rx_sh   <= '0;
      tcnt    <= '0;
      hcnt    <= '0;
      CS_N    <= '1;
      MOSI    <= 1'b1;
      RX_DATA <= '0;
      BUSY    <= 1'b0;
      SPI_FIN <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CS_N    <= '1;
          MOSI    <= 1'b1;
          BUSY    <= 1'b0;
          SPI_FIN <= 1'b0;
          if (SPI_EN) begin
            tx_lat <= TX_DATA;
            mode   <= '{cpol: CPOL, cpha: CPHA, lsb_first: LSB_FIRST};
            rx_sh  <= '0;
            tcnt   <= '0;
            hcnt   <= '0;
            CS_N   <= ~sel_mask;
            MOSI   <= CPHA ? 1'b1 : TX_DATA[first_idx];
            BUSY   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP, XFER: begin
          if (toggle) begin
            tcnt <= tcnt + TW'(1);
            if (lead) begin
              if (mode.cpha) MOSI <= tx_lat[cur_idx];
              else           rx_sh[cur_idx] <= MISO;
            end
            if (trail) begin
              if (mode.cpha)      rx_sh[cur_idx] <= MISO;
              else if (!last_bit) MOSI <= tx_lat[nxt_idx];
            end
            state <= (tcnt == TW'(2 * DATA_W - 1)) ? TRAIL : XFER;
          end
        end

        TRAIL: begin
          hcnt <= '0;
          if (tick) state <= HOLD;
        end

        HOLD: begin
          if (hcnt == HW'(CS_HOLD - 1)) begin
            CS_N    <= '1;
            MOSI    <= 1'b1;
            RX_DATA <= rx_sh;
            SPI_FIN <= 1'b1;
            state   <= DONE;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end

        DONE: begin
          if (!SPI_EN) begin
            SPI_FIN <= 1'b0;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
